// File: rtl/m2_block_fetch.sv
// m2_block_fetch: fetches one 8x8 block of 16-bit pre-IDCT coefficients per
// request from SRAM and writes it row-major into a 64-entry DP-RAM.
// Blocks are walked Y (40x30, stride 320), then U and V (20x30, stride 160).
//
// Ports:
//   CLOCK_50_I      clock
//   resetn          asynchronous active-low reset
//   fetch_start     request to fetch the next block (accepted only when idle)
//   fetch_done      one-cycle pulse once all 64 DP-RAM writes have completed
//   last_block      high with fetch_done when block 2399 was just fetched
//   block_index     index of the block targeted by the next/current fetch
//   SRAM_address    SRAM word address (holds its last value outside issue)
//   SRAM_we_n       tied high, reads only
//   SRAM_read_data  SRAM read data, valid SRAM_LAT cycles after the address
//   DP_address      DP-RAM write address, r*8+c
//   DP_write_data   DP-RAM write data (coefficient, unmodified)
//   DP_we           DP-RAM write enable
//
// FIRST_BLOCK selects the block the sequence counters reset to; the default
// of 0 is the normal sequence start.
module m2_block_fetch #(
  parameter logic [17:0] PRE_IDCT_BASE = 18'd76800,
  parameter int unsigned SRAM_LAT      = 2,
  parameter int unsigned FIRST_BLOCK   = 0
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        fetch_start,
  output logic        fetch_done,
  output logic        last_block,
  output logic [11:0] block_index,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic [5:0]  DP_address,
  output logic [15:0] DP_write_data,
  output logic        DP_we
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  typedef enum logic [1:0] {SEG_Y, SEG_U, SEG_V} seg_t;

  localparam int unsigned NUM_Y = 1200;
  localparam int unsigned NUM_U = 600;
  localparam int unsigned CB_Y  = 40;
  localparam int unsigned CB_UV = 20;
  localparam logic [11:0] LAST_IDX = 12'd2399;
  localparam logic [17:0] OFF_U    = 18'd76800;
  localparam logic [17:0] OFF_V    = 18'd115200;

  localparam int unsigned FB_REL = (FIRST_BLOCK < NUM_Y) ? FIRST_BLOCK :
                                   ((FIRST_BLOCK < NUM_Y + NUM_U) ? FIRST_BLOCK - NUM_Y :
                                                                    FIRST_BLOCK - NUM_Y - NUM_U);
  localparam int unsigned FB_CBN = (FIRST_BLOCK < NUM_Y) ? CB_Y : CB_UV;
  localparam logic [5:0]  RST_CB  = 6'(FB_REL % FB_CBN);
  localparam logic [4:0]  RST_RB  = 5'(FB_REL / FB_CBN);
  localparam logic [11:0] RST_IDX = 12'(FIRST_BLOCK);
  localparam seg_t        RST_SEG = (FIRST_BLOCK < NUM_Y) ? SEG_Y :
                                    ((FIRST_BLOCK < NUM_Y + NUM_U) ? SEG_U : SEG_V);

  state_t      state, state_n;
  seg_t        seg;
  logic [5:0]  cb;
  logic [4:0]  rb;
  logic [5:0]  cnt;
  logic [15:0] rd_q;

  // Read data is registered once before use, so the tag pipe is one slot
  // deeper than the SRAM latency.
  logic [SRAM_LAT:0] tag_vld;
  logic [5:0]        tag_idx [SRAM_LAT+1];

  assign SRAM_we_n = 1'b1;

  // Word address of element k of the current block.
  function automatic logic [17:0] elem_addr(input logic [5:0] k);
    logic [17:0] row;
    logic [17:0] col;
    logic [17:0] row_off;
    logic [17:0] seg_off;
    row = {10'd0, rb, k[5:3]};
    col = {9'd0, cb, k[2:0]};
    case (seg)
      SEG_Y: begin
        row_off = (row << 8) + (row << 6);
        seg_off = '0;
      end
      SEG_U: begin
        row_off = (row << 7) + (row << 5);
        seg_off = OFF_U;
      end
      default: begin
        row_off = (row << 7) + (row << 5);
        seg_off = OFF_V;
      end
    endcase
    return PRE_IDCT_BASE + seg_off + row_off + col;
  endfunction

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n    = state;
    fetch_done = 1'b0;
    last_block = 1'b0;
    case (state)
      S_IDLE:  if (fetch_start) state_n = S_ISSUE;
      S_ISSUE: if (cnt == 6'd63) state_n = S_DRAIN;
      // Pipe empties in the cycle the final DP write is presented.
      S_DRAIN: if (~|tag_vld) state_n = S_DONE;
      S_DONE: begin
        fetch_done = 1'b1;
        last_block = (block_index == LAST_IDX);
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      cnt           <= '0;
      SRAM_address  <= '0;
      rd_q          <= '0;
      tag_vld       <= '0;
      for (int unsigned i = 0; i <= SRAM_LAT; i++) tag_idx[i] <= '0;
      DP_we         <= 1'b0;
      DP_address    <= '0;
      DP_write_data <= '0;
      cb            <= RST_CB;
      rb            <= RST_RB;
      seg           <= RST_SEG;
      block_index   <= RST_IDX;
    end else begin
      rd_q       <= SRAM_read_data;
      tag_vld    <= {tag_vld[SRAM_LAT-1:0], state == S_ISSUE};
      tag_idx[0] <= cnt;
      for (int unsigned i = 1; i <= SRAM_LAT; i++) tag_idx[i] <= tag_idx[i-1];

      DP_we <= tag_vld[SRAM_LAT];
      if (tag_vld[SRAM_LAT]) begin
        DP_address    <= tag_idx[SRAM_LAT];
        DP_write_data <= rd_q;
      end

      case (state)
        S_IDLE: begin
          if (fetch_start) begin
            cnt          <= '0;
            SRAM_address <= elem_addr(6'd0);
          end
        end
        S_ISSUE: begin
          cnt <= cnt + 6'd1;
          if (cnt != 6'd63) SRAM_address <= elem_addr(cnt + 6'd1);
        end
        S_DONE: begin
          if (block_index == LAST_IDX) begin
            block_index <= '0;
            cb          <= '0;
            rb          <= '0;
            seg         <= SEG_Y;
          end else begin
            block_index <= block_index + 12'd1;
            if (cb == ((seg == SEG_Y) ? 6'd39 : 6'd19)) begin
              cb <= '0;
              if (rb == 5'd29) begin
                rb  <= '0;
                seg <= (seg == SEG_Y) ? SEG_U : SEG_V;
              end else begin
                rb <= rb + 5'd1;
              end
            end else begin
              cb <= cb + 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
